// File: rtl/cart_mem_router.sv
// Routes cartridge and host requests onto one backing-memory port.
// A pending cartridge request always wins over the host; each access ends with a single response cycle.
module cart_mem_router #(
  parameter int unsigned TIMEOUT = 64,
  parameter bit          HOST_EN = 1'b1,
  localparam int unsigned AW     = 26,
  localparam int unsigned DW     = 16,
  localparam int unsigned WW     = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_cart_rd,
  input  logic          i_cart_wr,
  input  logic [AW-1:0] i_cart_addr,
  input  logic [WW-1:0] i_cart_data_width,
  input  logic [DW-1:0] i_cart_wr_data,
  output logic [DW-1:0] o_cart_rd_data,
  output logic          o_cart_rd_valid,
  input  logic          i_host_req,
  input  logic          i_host_we,
  input  logic [AW-1:0] i_host_addr,
  input  logic [DW-1:0] i_host_wdata,
  output logic [DW-1:0] o_host_rdata,
  output logic          o_host_ack,
  output logic          o_mem_req,
  output logic          o_mem_we,
  output logic [AW-1:0] o_mem_addr,
  output logic [1:0]    o_mem_be,
  output logic [DW-1:0] o_mem_wdata,
  input  logic [DW-1:0] i_mem_rdata,
  input  logic          i_mem_ack,
  output logic          o_err_timeout,
  output logic          o_err_overrun
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CART, S_HOST, S_RESP} state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic            r_pend_vld;
  logic            r_pend_we;
  logic            r_pend_byte;
  logic [AW-1:0]   r_pend_addr;
  logic [DW-1:0]   r_pend_wdata;

  logic            r_mem_req;
  logic            r_mem_we;
  logic [AW-1:0]   r_mem_addr;
  logic [1:0]      r_mem_be;
  logic [DW-1:0]   r_mem_wdata;
  logic            r_is_host;
  logic            r_rd_byte;
  logic [CW-1:0]   r_cnt;

  logic            r_cart_rd_valid;
  logic [DW-1:0]   r_cart_rd_data;
  logic            r_host_ack;
  logic [DW-1:0]   r_host_rdata;
  logic            r_err_timeout;
  logic            r_err_overrun;

  logic            w_pulse;
  logic            w_pulse_byte;
  logic            w_slot_vld;
  logic            w_slot_we;
  logic            w_slot_byte;
  logic [AW-1:0]   w_slot_addr;
  logic [DW-1:0]   w_slot_wdata;
  logic            w_host_go;
  logic            w_ack;
  logic            w_tmo;
  logic [DW-1:0]   w_rsp_data;
  logic [DW-1:0]   w_cart_rdata;
  logic            w_issue_cart;
  logic            w_issue_host;
  logic            w_done;

  // A live pulse is the newest request, so it is the one issued when it meets an unissued slot.
  assign w_pulse      = (i_cart_rd | i_cart_wr) & (i_cart_data_width != 2'b00);
  assign w_pulse_byte = (i_cart_data_width == 2'b01);
  assign w_slot_vld   = w_pulse | r_pend_vld;
  assign w_slot_we    = w_pulse ? i_cart_wr      : r_pend_we;
  assign w_slot_byte  = w_pulse ? w_pulse_byte   : r_pend_byte;
  assign w_slot_addr  = w_pulse ? i_cart_addr    : r_pend_addr;
  assign w_slot_wdata = w_pulse ? i_cart_wr_data : r_pend_wdata;

  assign w_host_go    = (HOST_EN == 1'b1) & i_host_req;
  assign w_ack        = r_mem_req & i_mem_ack;
  assign w_tmo        = r_mem_req & ~i_mem_ack & (r_cnt == CW'(TIMEOUT - 1));
  assign w_rsp_data   = w_ack ? i_mem_rdata : 16'hFFFF;
  assign w_cart_rdata = (w_ack & r_rd_byte) ? {8'h00, i_mem_rdata[7:0]} : w_rsp_data;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_issue_cart = 1'b0;
    w_issue_host = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_slot_vld) begin
          w_state_nxt  = S_CART;
          w_issue_cart = 1'b1;
        end else if (w_host_go) begin
          w_state_nxt  = S_HOST;
          w_issue_host = 1'b1;
        end
      end
      S_CART, S_HOST: begin
        if (w_ack | w_tmo) begin
          w_state_nxt = S_RESP;
          w_done      = 1'b1;
        end
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Single-entry cartridge slot; a second unissued pulse overwrites it and flags overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend_vld    <= 1'b0;
      r_pend_we     <= 1'b0;
      r_pend_byte   <= 1'b0;
      r_pend_addr   <= '0;
      r_pend_wdata  <= '0;
      r_err_overrun <= 1'b0;
    end else begin
      if (w_pulse & r_pend_vld) r_err_overrun <= 1'b1;
      if (w_issue_cart) begin
        r_pend_vld <= 1'b0;
      end else if (w_pulse) begin
        r_pend_vld   <= 1'b1;
        r_pend_we    <= i_cart_wr;
        r_pend_byte  <= w_pulse_byte;
        r_pend_addr  <= i_cart_addr;
        r_pend_wdata <= i_cart_wr_data;
      end
    end
  end

  // Memory request is held stable from issue until ack or timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_be    <= 2'b00;
      r_mem_wdata <= '0;
      r_is_host   <= 1'b0;
      r_rd_byte   <= 1'b0;
      r_cnt       <= '0;
    end else if (w_issue_cart) begin
      r_mem_req   <= 1'b1;
      r_mem_we    <= w_slot_we;
      r_mem_addr  <= w_slot_addr;
      r_mem_be    <= w_slot_byte ? 2'b01 : 2'b11;
      r_mem_wdata <= w_slot_byte ? {8'h00, w_slot_wdata[7:0]} : w_slot_wdata;
      r_is_host   <= 1'b0;
      r_rd_byte   <= w_slot_byte;
      r_cnt       <= '0;
    end else if (w_issue_host) begin
      r_mem_req   <= 1'b1;
      r_mem_we    <= i_host_we;
      r_mem_addr  <= i_host_addr;
      r_mem_be    <= 2'b11;
      r_mem_wdata <= i_host_wdata;
      r_is_host   <= 1'b1;
      r_rd_byte   <= 1'b0;
      r_cnt       <= '0;
    end else if (w_done) begin
      r_mem_req   <= 1'b0;
      r_cnt       <= '0;
    end else if (r_mem_req) begin
      r_cnt       <= r_cnt + CW'(1);
    end
  end

  // Response registers: one-cycle strobes raised in the cycle after completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cart_rd_valid <= 1'b0;
      r_cart_rd_data  <= '0;
      r_host_ack      <= 1'b0;
      r_host_rdata    <= '0;
      r_err_timeout   <= 1'b0;
    end else begin
      r_cart_rd_valid <= 1'b0;
      r_host_ack      <= 1'b0;
      if (w_done) begin
        if (w_tmo) r_err_timeout <= 1'b1;
        if (r_is_host) begin
          r_host_ack <= 1'b1;
          if (!r_mem_we) r_host_rdata <= w_rsp_data;
        end else if (!r_mem_we) begin
          r_cart_rd_valid <= 1'b1;
          r_cart_rd_data  <= w_cart_rdata;
        end
      end
    end
  end

  assign o_cart_rd_data  = r_cart_rd_data;
  assign o_cart_rd_valid = r_cart_rd_valid;
  assign o_host_rdata    = r_host_rdata;
  assign o_host_ack      = r_host_ack;
  assign o_mem_req       = r_mem_req;
  assign o_mem_we        = r_mem_we;
  assign o_mem_addr      = r_mem_addr;
  assign o_mem_be        = r_mem_be;
  assign o_mem_wdata     = r_mem_wdata;
  assign o_err_timeout   = r_err_timeout;
  assign o_err_overrun   = r_err_overrun;

endmodule

// File: tb/tb_cart_mem_router.sv
// Directed bench for cart_mem_router: transaction-level expectation queue checked every cycle,
// plus literal expectations for the headline scenarios.
module tb_cart_mem_router;

  localparam int unsigned TIMEOUT = 64;
  localparam int K_CRD = 1;
  localparam int K_CWR = 2;
  localparam int K_HRD = 3;
  localparam int K_HWR = 4;

  logic        clk;
  logic        rst;
  logic        i_cart_rd, i_cart_wr;
  logic [25:0] i_cart_addr;
  logic [1:0]  i_cart_data_width;
  logic [15:0] i_cart_wr_data;
  logic [15:0] o_cart_rd_data;
  logic        o_cart_rd_valid;
  logic        i_host_req, i_host_we;
  logic [25:0] i_host_addr;
  logic [15:0] i_host_wdata;
  logic [15:0] o_host_rdata;
  logic        o_host_ack;
  logic        o_mem_req, o_mem_we;
  logic [25:0] o_mem_addr;
  logic [1:0]  o_mem_be;
  logic [15:0] o_mem_wdata;
  logic [15:0] i_mem_rdata;
  logic        i_mem_ack;
  logic        o_err_timeout, o_err_overrun;

  cart_mem_router #(.TIMEOUT(TIMEOUT), .HOST_EN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .i_cart_rd(i_cart_rd), .i_cart_wr(i_cart_wr), .i_cart_addr(i_cart_addr),
    .i_cart_data_width(i_cart_data_width), .i_cart_wr_data(i_cart_wr_data),
    .o_cart_rd_data(o_cart_rd_data), .o_cart_rd_valid(o_cart_rd_valid),
    .i_host_req(i_host_req), .i_host_we(i_host_we), .i_host_addr(i_host_addr),
    .i_host_wdata(i_host_wdata), .o_host_rdata(o_host_rdata), .o_host_ack(o_host_ack),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_be(o_mem_be), .o_mem_wdata(o_mem_wdata),
    .i_mem_rdata(i_mem_rdata), .i_mem_ack(i_mem_ack),
    .o_err_timeout(o_err_timeout), .o_err_overrun(o_err_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    logic        we;
    logic [25:0] addr;
    logic [1:0]  be;
    logic [15:0] wdata;
    logic        is_byte;
  } req_t;

  req_t        exp_q[$];
  int          n_chk = 0;
  int          n_err = 0;
  logic        mon_en;
  logic        m_tmo;
  logic        m_ovr;
  int          ack_lat;
  logic        force_ack;
  logic [15:0] rsp_base;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected memory request for a cartridge access, straight from the width rules.
  function automatic req_t cart_model(input logic wr, input logic [25:0] a,
                                      input logic [1:0] w, input logic [15:0] d);
    req_t r;
    r.kind    = wr ? K_CWR : K_CRD;
    r.we      = wr;
    r.addr    = a;
    r.is_byte = (w == 2'b01);
    r.be      = r.is_byte ? 2'b01 : 2'b11;
    r.wdata   = r.is_byte ? {8'h00, d[7:0]} : d;
    return r;
  endfunction

  function automatic req_t host_model(input logic we, input logic [25:0] a, input logic [15:0] d);
    req_t r;
    r.kind    = we ? K_HWR : K_HRD;
    r.we      = we;
    r.addr    = a;
    r.is_byte = 1'b0;
    r.be      = 2'b11;
    r.wdata   = d;
    return r;
  endfunction

  // Backing memory: acks ack_lat cycles after the request appears; data depends on address.
  initial begin
    int hold;
    hold = 0;
    i_mem_ack = 1'b0;
    i_mem_rdata = 16'h0;
    forever begin
      @(posedge clk);
      #2;
      if (o_mem_req === 1'b1) hold++;
      else hold = 0;
      i_mem_ack   = force_ack | ((ack_lat != 0) && (hold == ack_lat + 1));
      i_mem_rdata = i_mem_ack ? (rsp_base ^ o_mem_addr[15:0]) : 16'h0;
    end
  end

  // Per-cycle comparison against the expectation queue and response schedule.
  initial begin
    req_t        cur;
    logic        active, expect_low;
    int          due_k, req_cyc;
    logic [15:0] due_d;
    active = 0; expect_low = 0; due_k = 0; req_cyc = 0; due_d = '0; m_tmo = 0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        exp_q.delete();
        active = 0; expect_low = 0; due_k = 0; m_tmo = 0;
      end else begin
        if (expect_low) chk("mem_req_after_done", o_mem_req, 0);
        expect_low = 0;
        chk("cart_rd_valid", o_cart_rd_valid, 32'(due_k == K_CRD));
        chk("host_ack", o_host_ack, 32'((due_k == K_HRD) || (due_k == K_HWR)));
        if (due_k == K_CRD && o_cart_rd_valid) chk("cart_rd_data", o_cart_rd_data, due_d);
        if (due_k == K_HRD && o_host_ack) chk("host_rdata", o_host_rdata, due_d);
        due_k = 0;
        chk("err_timeout", o_err_timeout, m_tmo);
        chk("err_overrun", o_err_overrun, m_ovr);
        if (o_mem_req) begin
          if (!active) begin
            if (exp_q.size() == 0) chk("unexpected_mem_req", o_mem_req, 0);
            else begin
              cur = exp_q.pop_front();
              active = 1; req_cyc = 0;
            end
          end
          if (active) begin
            chk("mem_we", o_mem_we, cur.we);
            chk("mem_addr", o_mem_addr, cur.addr);
            chk("mem_be", o_mem_be, cur.be);
            if (cur.we) chk("mem_wdata", o_mem_wdata, cur.wdata);
            req_cyc++;
            if (i_mem_ack) begin
              due_k = cur.kind;
              due_d = cur.is_byte ? {8'h00, i_mem_rdata[7:0]} : i_mem_rdata;
              active = 0; expect_low = 1;
            end else if (req_cyc == TIMEOUT) begin
              due_k = cur.kind; due_d = 16'hFFFF;
              active = 0; expect_low = 1; m_tmo = 1;
            end
          end
        end else if (active) begin
          chk("mem_req_held", o_mem_req, 1);
          active = 0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cart_pulse(input logic rd, input logic wr, input logic [25:0] a,
                            input logic [1:0] w, input logic [15:0] d);
    i_cart_rd = rd; i_cart_wr = wr; i_cart_addr = a; i_cart_data_width = w; i_cart_wr_data = d;
    step();
    i_cart_rd = 0; i_cart_wr = 0; i_cart_data_width = 2'b00; i_cart_wr_data = 16'h0;
  endtask

  task automatic wait_cart(input int max, output int lat);
    lat = -1;
    for (int k = 1; k <= max && lat < 0; k++) begin
      step();
      if (o_cart_rd_valid) lat = k;
    end
    if (lat < 0) chk("wait_cart_rd_valid", o_cart_rd_valid, 1);
  endtask

  task automatic wait_host(input int max);
    int got;
    got = 0;
    for (int k = 1; k <= max && got == 0; k++) begin
      step();
      if (o_host_ack) begin
        got = 1;
        i_host_req = 1'b0;
      end
    end
    if (got == 0) begin
      chk("wait_host_ack", o_host_ack, 1);
      i_host_req = 1'b0;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_mem_req"}, o_mem_req, 0);
    chk({tag, "_mem_we"}, o_mem_we, 0);
    chk({tag, "_mem_be"}, o_mem_be, 0);
    chk({tag, "_mem_addr"}, o_mem_addr, 0);
    chk({tag, "_mem_wdata"}, o_mem_wdata, 0);
    chk({tag, "_cart_rd_valid"}, o_cart_rd_valid, 0);
    chk({tag, "_cart_rd_data"}, o_cart_rd_data, 0);
    chk({tag, "_host_ack"}, o_host_ack, 0);
    chk({tag, "_host_rdata"}, o_host_rdata, 0);
    chk({tag, "_err_timeout"}, o_err_timeout, 0);
    chk({tag, "_err_overrun"}, o_err_overrun, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, t_cart, t_host, req_cnt;
    rst = 1; mon_en = 0; m_ovr = 0; force_ack = 0; ack_lat = 0; rsp_base = 16'h0;
    i_cart_rd = 0; i_cart_wr = 0; i_cart_addr = '0; i_cart_data_width = 2'b00; i_cart_wr_data = '0;
    i_host_req = 0; i_host_we = 0; i_host_addr = '0; i_host_wdata = '0;
    step(); step();
    check_reset_vals("reset");
    rst = 0; mon_en = 1;
    step();

    // Halfword cart read, ack three cycles after request.
    ack_lat = 3; rsp_base = 16'hBFEF;
    exp_q.push_back(cart_model(1'b0, 26'h0000100, 2'b10, 16'h0));
    cart_pulse(1, 0, 26'h0000100, 2'b10, 16'h0);
    chk("t1_req_next_cycle", o_mem_req, 1);
    chk("t1_mem_be", o_mem_be, 2'b11);
    wait_cart(20, lat);
    chk("t1_latency", 32'(lat), 4);
    chk("t1_rd_data", o_cart_rd_data, 16'hBEEF);
    step();
    chk("t1_valid_one_cycle", o_cart_rd_valid, 0);
    step();

    // Byte write to SRAM region.
    ack_lat = 2;
    exp_q.push_back(cart_model(1'b1, 26'h2000010, 2'b01, 16'h12AB));
    cart_pulse(0, 1, 26'h2000010, 2'b01, 16'h12AB);
    chk("t2_mem_we", o_mem_we, 1);
    chk("t2_mem_be", o_mem_be, 2'b01);
    chk("t2_mem_wdata", o_mem_wdata, 16'h00AB);
    chk("t2_mem_addr", o_mem_addr, 26'h2000010);
    repeat (6) step();

    // Byte read returns zero-extended low byte.
    ack_lat = 1; rsp_base = 16'h12C4;
    exp_q.push_back(cart_model(1'b0, 26'h0000201, 2'b01, 16'h0));
    cart_pulse(1, 0, 26'h0000201, 2'b01, 16'h0);
    wait_cart(10, lat);
    chk("t3_byte_rd_data", o_cart_rd_data, 16'h00C5);
    step();

    // Cart pulse and host read in the same cycle: cart goes first.
    ack_lat = 1; rsp_base = 16'hA5A5;
    exp_q.push_back(cart_model(1'b0, 26'h0000040, 2'b10, 16'h0));
    exp_q.push_back(host_model(1'b0, 26'h0000400, 16'h0));
    i_host_req = 1; i_host_we = 0; i_host_addr = 26'h0000400;
    cart_pulse(1, 0, 26'h0000040, 2'b10, 16'h0);
    t_cart = -1; t_host = -1;
    for (int k = 1; k <= 40 && t_host < 0; k++) begin
      step();
      if (o_cart_rd_valid && t_cart < 0) begin
        t_cart = k;
        chk("t4_cart_data", o_cart_rd_data, 16'hA5E5);
      end
      if (o_host_ack) begin
        t_host = k;
        i_host_req = 0;
        chk("t4_host_data", o_host_rdata, 16'hA1A5);
      end
    end
    i_host_req = 0;
    chk("t4_cart_before_host", 32'((t_cart > 0) && (t_cart < t_host)), 1);
    step();

    // Two cart pulses while a host read is in flight: overrun, only the second issued.
    ack_lat = 6; rsp_base = 16'h3C00;
    exp_q.push_back(host_model(1'b0, 26'h0000600, 16'h0));
    i_host_req = 1; i_host_we = 0; i_host_addr = 26'h0000600;
    step();
    chk("t5_host_in_flight", o_mem_req, 1);
    cart_pulse(1, 0, 26'h0000700, 2'b10, 16'h0);
    cart_pulse(1, 0, 26'h0000800, 2'b10, 16'h0);
    m_ovr = 1;
    exp_q.push_back(cart_model(1'b0, 26'h0000800, 2'b10, 16'h0));
    wait_host(20);
    wait_cart(20, lat);
    chk("t5_second_addr_data", o_cart_rd_data, 16'h3400);
    chk("t5_err_overrun", o_err_overrun, 1);
    step();

    // Host write passes data unchanged with both byte lanes.
    ack_lat = 2;
    exp_q.push_back(host_model(1'b1, 26'h0000050, 16'hCAFE));
    i_host_req = 1; i_host_we = 1; i_host_addr = 26'h0000050; i_host_wdata = 16'hCAFE;
    step();
    chk("t6_mem_wdata", o_mem_wdata, 16'hCAFE);
    chk("t6_mem_be", o_mem_be, 2'b11);
    wait_host(10);
    i_host_we = 0;
    step();

    // Zero width is ignored; read+write together is a write.
    ack_lat = 1;
    cart_pulse(1, 0, 26'h0000030, 2'b00, 16'h0);
    for (int k = 0; k < 4; k++) begin
      chk("t8_width0_ignored", o_mem_req, 0);
      step();
    end
    exp_q.push_back(cart_model(1'b1, 26'h0000020, 2'b10, 16'h7777));
    cart_pulse(1, 1, 26'h0000020, 2'b10, 16'h7777);
    chk("t8_rdwr_is_write", o_mem_we, 1);
    chk("t8_wdata", o_mem_wdata, 16'h7777);
    repeat (5) step();

    // No ack ever: timeout after TIMEOUT request cycles.
    ack_lat = 0;
    exp_q.push_back(cart_model(1'b0, 26'h0000300, 2'b10, 16'h0));
    cart_pulse(1, 0, 26'h0000300, 2'b10, 16'h0);
    req_cnt = 1; lat = -1;
    for (int k = 1; k <= 100 && lat < 0; k++) begin
      step();
      if (o_cart_rd_valid) lat = k;
      else if (o_mem_req) req_cnt++;
    end
    chk("t7_req_cycles", 32'(req_cnt), TIMEOUT);
    chk("t7_valid_seen", o_cart_rd_valid, 1);
    chk("t7_rd_data", o_cart_rd_data, 16'hFFFF);
    chk("t7_err_timeout", o_err_timeout, 1);
    repeat (5) step();
    chk("t7_err_sticky", o_err_timeout, 1);

    // Reset mid-access, then a late ack: no response, everything back to reset values.
    exp_q.push_back(cart_model(1'b0, 26'h0000900, 2'b10, 16'h0));
    cart_pulse(1, 0, 26'h0000900, 2'b10, 16'h0);
    step(); step();
    chk("t9_req_before_rst", o_mem_req, 1);
    mon_en = 0; rst = 1;
    step();
    rst = 0; m_ovr = 0; force_ack = 1;
    step();
    force_ack = 0;
    check_reset_vals("t9");
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t9_no_valid", o_cart_rd_valid, 0);
      chk("t9_no_req", o_mem_req, 0);
    end
    mon_en = 1;
    step();

    // Normal traffic after reset.
    ack_lat = 1; rsp_base = 16'h0000;
    exp_q.push_back(cart_model(1'b0, 26'h0000A00, 2'b10, 16'h0));
    cart_pulse(1, 0, 26'h0000A00, 2'b10, 16'h0);
    wait_cart(10, lat);
    chk("t10_latency", 32'(lat), 2);
    chk("t10_rd_data", o_cart_rd_data, 16'h0A00);
    repeat (3) step();
    chk("t10_queue_drained", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/cart_mem_router.md
CART_MEM_ROUTER -- requirements
Module: cart_mem_router

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64: max cycles waiting for mem_ack before abort.
REQ-002 SHALL have parameter HOST_EN, default 1: 0 ties host_ack low and ignores host_req.
REQ-003 SHALL have port clk  input  1  clock, all logic rising-edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports cart_rd, cart_wr  input  1 each  single-cycle request pulses from the cartridge front end.
REQ-006 SHALL have port cart_addr  input  26  bit25=0 ROM region (byte address), bit25=1 SRAM region (address in [15:0]).
REQ-007 SHALL have port cart_data_width  input  2  2'b10 halfword, 2'b01 byte, 2'b00 none.
REQ-008 SHALL have port cart_wr_data  input  16  write data, valid in the cart_wr cycle only.
REQ-009 SHALL have ports cart_rd_data  output  16 and cart_rd_valid  output  1  read response, valid for exactly one cycle.
REQ-010 SHALL have ports host_req, host_we  input  1; host_addr  input  26; host_wdata  input  16  host (debug/loader) request, level-held until ack.
REQ-011 SHALL have ports host_rdata  output  16; host_ack  output  1  single-cycle completion.
REQ-012 SHALL have ports mem_req, mem_we  output  1; mem_addr  output  26; mem_be  output  2; mem_wdata  output  16  backing memory request, held until mem_ack.
REQ-013 SHALL have ports mem_rdata  input  16; mem_ack  input  1  single-cycle memory completion.
REQ-014 SHALL have ports err_timeout, err_overrun  output  1  sticky error flags.

Function
REQ-015 SHALL implement FSM states IDLE, CART, HOST, RESP.
REQ-016 SHALL latch cart_rd/cart_wr pulse (with addr, width, wr_data) into a single-entry pending slot in the cycle of the pulse, in any state.
REQ-017 SHALL, in IDLE, prioritise pending cart over host_req; go to CART with mem_req asserted next cycle (cart pulse cycle N -> mem_req at N+1).
REQ-018 SHALL go IDLE->HOST only if no cart pending and host_req=1 and HOST_EN=1.
REQ-019 SHALL hold mem_req, mem_addr, mem_we, mem_be, mem_wdata stable from assertion until the mem_ack cycle; deassert mem_req the cycle after mem_ack.
REQ-020 SHALL map halfword access to mem_be=2'b11; byte access to mem_be=2'b01 with mem_wdata={8'h00,cart_wr_data[7:0]}.
REQ-021 SHALL, for byte reads, return cart_rd_data={8'h00,mem_rdata[7:0]}.
REQ-022 SHALL register read data: mem_ack at cycle M -> cart_rd_valid=1 at M+1 with data; cart writes produce no cart_rd_valid.
REQ-023 SHALL pulse host_ack (and host_rdata for reads) at M+1 for host accesses; never preempt an in-flight host access.
REQ-024 SHALL use RESP as the single response cycle, then return to IDLE; a pending cart request is served from IDLE the following cycle.
REQ-025 SHALL count cycles from mem_req assertion; on reaching TIMEOUT without mem_ack: drop mem_req, set err_timeout, return 16'hFFFF on read response (cart_rd_valid or host_ack), complete writes silently.
REQ-026 SHALL set err_overrun when a cart pulse arrives while the pending slot is still occupied (not yet issued); the new request overwrites the slot.
REQ-027 SHALL treat cart_rd and cart_wr both high in one cycle as a write; cart_data_width=2'b00 with a pulse is ignored.
REQ-028 SHALL ignore mem_ack arriving while mem_req is low.

Reset
REQ-029 SHALL, on rst, clear state to IDLE, pending slot, timeout counter, err flags; drive mem_req, mem_we, cart_rd_valid, host_ack=0, all data/address outputs=0, mem_be=2'b00.
REQ-030 SHALL abandon any in-flight access on rst mid-operation, issue no response, and drop a late mem_ack.

Verification
REQ-031 Cart halfword read addr 26'h0000100, mem_ack 3 cycles after mem_req with 16'hBEEF -> cart_rd_valid one cycle, data 16'hBEEF, mem_be=2'b11.
REQ-032 Cart byte write addr 26'h2000010, data 16'h12AB -> mem_we=1, mem_be=2'b01, mem_wdata=16'h00AB, no cart_rd_valid.
REQ-033 host_req read pending plus cart_rd same cycle -> cart access issued first, host_ack only after cart_rd_valid.
REQ-034 Cart read, mem_ack never asserted -> after TIMEOUT=64 cycles mem_req drops, cart_rd_valid with 16'hFFFF, err_timeout=1 until rst.
REQ-035 Two cart_rd pulses during an in-flight host access -> err_overrun=1, only second address issued.
REQ-036 rst asserted while mem_req high, then mem_ack -> no response outputs, all outputs at reset values.
